// File: rtl/multimem_pkg.sv
// Shared types and defaults for the double-buffered LED frame memory.
// Holds the swap FSM encoding and a constant-foldable clog2.
package multimem_pkg;

    localparam int WR_WIDTH_DEF      = 8;
    localparam int RD_WIDTH_DEF      = 16;
    localparam int RD_ADDR_WIDTH_DEF = 11;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } swap_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram_lane.sv
// One lane of one bank: simple dual-port RAM, single clock,
// synchronous read, no reset on storage.
module dpram_lane #(
    parameter int DW = 8,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end

endmodule

// File: rtl/multimem_dbuf.sv
// Ping-pong frame memory: narrow writes to the back bank, wide reads
// from the front bank, swap held off until the scan frame boundary.
module multimem_dbuf
    import multimem_pkg::*;
#(
    parameter  int WR_WIDTH      = WR_WIDTH_DEF,
    parameter  int RD_WIDTH      = RD_WIDTH_DEF,
    parameter  int RD_ADDR_WIDTH = RD_ADDR_WIDTH_DEF,
    localparam int RATIO         = RD_WIDTH / WR_WIDTH,
    localparam int LW            = clog2(RATIO),
    localparam int WR_ADDR_WIDTH = RD_ADDR_WIDTH + LW
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [WR_WIDTH-1:0]      DataInA,
    input  logic [WR_ADDR_WIDTH-1:0] AddressA,
    input  logic                     WrA,
    input  logic [RD_ADDR_WIDTH-1:0] AddressB,
    input  logic                     RdB,
    output logic [RD_WIDTH-1:0]      QB,
    output logic                     QBValid,
    input  logic                     SwapReq,
    input  logic                     FrameSync,
    output logic                     SwapPend,
    output logic                     SwapDone,
    output logic                     FrontBank
);

    localparam int LSW = (LW == 0) ? 1 : LW;

    swap_state_t state;
    logic [RD_ADDR_WIDTH-1:0] wr_word;
    logic [LSW-1:0] wr_lane;
    logic [1:0][RD_WIDTH-1:0] bank_q;
    logic rd_v1;
    logic rd_bank;

    assign wr_word  = AddressA[WR_ADDR_WIDTH-1:LW];
    assign SwapPend = (state == PEND);

    if (LW == 0) begin : g_one_lane
        assign wr_lane = '0;
    end else begin : g_lanes
        assign wr_lane = AddressA[LSW-1:0];
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar l = 0; l < RATIO; l++) begin : g_lane
            dpram_lane #(
                .DW(WR_WIDTH),
                .AW(RD_ADDR_WIDTH)
            ) u_lane (
                .clk(Clock),
                .we (WrA && (1'(b) != FrontBank) && (wr_lane == LSW'(l))),
                .wa (wr_word),
                .wd (DataInA),
                .re (RdB),
                .ra (AddressB),
                .rd (bank_q[b][l*WR_WIDTH +: WR_WIDTH])
            );
        end
    end

    // rd_bank captures the pre-swap front bank alongside the RAM read
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            FrontBank <= 1'b0;
            SwapDone  <= 1'b0;
            rd_v1     <= 1'b0;
            rd_bank   <= 1'b0;
            QBValid   <= 1'b0;
            QB        <= '0;
        end else begin
            rd_v1    <= RdB;
            rd_bank  <= FrontBank;
            QBValid  <= rd_v1;
            SwapDone <= 1'b0;
            if (rd_v1) QB <= bank_q[rd_bank];
            unique case (state)
                IDLE: begin
                    if (SwapReq && FrameSync) begin
                        FrontBank <= ~FrontBank;
                        SwapDone  <= 1'b1;
                    end else if (SwapReq) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (FrameSync) begin
                        FrontBank <= ~FrontBank;
                        SwapDone  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multimem_dbuf.sv
// Bench for multimem_dbuf: cycle model of banks and swap FSM,
// read scoreboard queue, plus a vector table for the basic flow.
module tb_multimem_dbuf;

    logic        clk;
    logic        Reset;
    logic [7:0]  DataInA;
    logic [11:0] AddressA;
    logic        WrA;
    logic [10:0] AddressB;
    logic        RdB;
    logic [15:0] QB;
    logic        QBValid;
    logic        SwapReq;
    logic        FrameSync;
    logic        SwapPend;
    logic        SwapDone;
    logic        FrontBank;

    multimem_dbuf dut (
        .Clock    (clk),
        .Reset    (Reset),
        .DataInA  (DataInA),
        .AddressA (AddressA),
        .WrA      (WrA),
        .AddressB (AddressB),
        .RdB      (RdB),
        .QB       (QB),
        .QBValid  (QBValid),
        .SwapReq  (SwapReq),
        .FrameSync(FrameSync),
        .SwapPend (SwapPend),
        .SwapDone (SwapDone),
        .FrontBank(FrontBank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [2][2048];
    logic        m_front = 1'b0;
    logic        m_pend  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_v1    = 1'b0;
    logic        m_v2    = 1'b0;
    logic [15:0] sb [$];

    typedef struct {
        logic        rst;
        logic        wr;
        logic [11:0] wa;
        logic [7:0]  wd;
        logic        rd;
        logic [10:0] ra;
        logic        sreq;
        logic        fs;
        logic        exp_pend;
        logic        exp_front;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic wr,
                       input logic [11:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [10:0] ra,
                       input logic sreq, input logic fs);
        Reset     = rst;
        WrA       = wr;
        AddressA  = wa;
        DataInA   = wd;
        RdB       = rd;
        AddressB  = ra;
        SwapReq   = sreq;
        FrameSync = fs;
        @(posedge clk);
        if (rst) begin
            m_front = 1'b0;
            m_pend  = 1'b0;
            m_done  = 1'b0;
            m_v1    = 1'b0;
            m_v2    = 1'b0;
            sb.delete();
        end else begin
            if (rd) sb.push_back(mdl[m_front][ra]);
            m_v2 = m_v1;
            m_v1 = rd;
            if (wr) mdl[!m_front][wa[11:1]][int'(wa[0])*8 +: 8] = wd;
            m_done = 1'b0;
            if (!m_pend) begin
                if (sreq && fs) begin
                    m_front = !m_front;
                    m_done  = 1'b1;
                end else if (sreq) begin
                    m_pend = 1'b1;
                end
            end else if (fs) begin
                m_front = !m_front;
                m_pend  = 1'b0;
                m_done  = 1'b1;
            end
        end
        #1;
        chk("qbvalid", 32'(QBValid), 32'(m_v2));
        chk("swappend", 32'(SwapPend), 32'(m_pend));
        chk("swapdone", 32'(SwapDone), 32'(m_done));
        chk("frontbank", 32'(FrontBank), 32'(m_front));
        if (m_v2) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL qb: got %0h expected none queued", QB);
            end else begin
                chk("qb", 32'(QB), 32'(sb.pop_front()));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr16(input logic [10:0] w, input logic [15:0] d);
        cyc(0, 1, {w, 1'b0}, d[7:0], 0, 0, 0, 0);
        cyc(0, 1, {w, 1'b1}, d[15:8], 0, 0, 0, 0);
    endtask

    task automatic rd1(input logic [10:0] a);
        cyc(0, 0, 0, 0, 1, a, 0, 0);
        idle(2);
    endtask

    task automatic swap();
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    logic f0;

    initial begin
        tv[0] = '{1, 0, 12'd0, 8'h00, 0, 11'd0, 0, 0, 0, 0};
        tv[1] = '{0, 1, 12'd0, 8'hA5, 0, 11'd0, 0, 0, 0, 0};
        tv[2] = '{0, 1, 12'd1, 8'h3C, 0, 11'd0, 0, 0, 0, 0};
        tv[3] = '{0, 0, 12'd0, 8'h00, 0, 11'd0, 1, 0, 1, 0};
        tv[4] = '{0, 0, 12'd0, 8'h00, 0, 11'd0, 0, 0, 1, 0};
        tv[5] = '{0, 0, 12'd0, 8'h00, 0, 11'd0, 0, 1, 0, 1};
        tv[6] = '{0, 0, 12'd0, 8'h00, 1, 11'd0, 0, 0, 0, 1};
        tv[7] = '{0, 0, 12'd0, 8'h00, 0, 11'd0, 0, 0, 0, 1};
        tv[8] = '{0, 0, 12'd0, 8'h00, 0, 11'd0, 0, 0, 0, 1};

        // 1: basic load, swap, wide read
        for (int i = 0; i < 9; i++) begin
            cyc(tv[i].rst, tv[i].wr, tv[i].wa, tv[i].wd,
                tv[i].rd, tv[i].ra, tv[i].sreq, tv[i].fs);
            chk("t1_pend", 32'(SwapPend), 32'(tv[i].exp_pend));
            chk("t1_front", 32'(FrontBank), 32'(tv[i].exp_front));
            if (i == 0) chk("t1_rst_qb", 32'(QB), 32'h0);
        end
        chk("t1_qb", 32'(QB), 32'h3CA5);

        // 2: partial lane write keeps the other lane
        wr16(11'd5, 16'h1234);
        swap();
        wr16(11'd5, 16'h1234);
        rd1(11'd5);
        chk("t2_pre", 32'(QB), 32'h1234);
        cyc(0, 1, 12'd11, 8'hFF, 0, 0, 0, 0);
        swap();
        rd1(11'd5);
        chk("t2_qb", 32'(QB), 32'hFF34);

        // 3: repeated SwapReq while pending
        f0 = FrontBank;
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            idle(1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        chk("t3_front", 32'(FrontBank), 32'(!f0));

        // 4: simultaneous SwapReq/FrameSync with a write on the swap edge
        f0 = FrontBank;
        cyc(0, 1, 12'd21, 8'h66, 0, 0, 0, 0);
        cyc(0, 1, 12'd20, 8'h77, 0, 0, 1, 1);
        chk("t4_front", 32'(FrontBank), 32'(!f0));
        idle(1);
        rd1(11'd10);
        chk("t4_qb", 32'(QB), 32'h6677);

        // 5: streaming reads across a swap edge
        for (int i = 0; i < 4; i++) wr16(11'(100 + i), 16'hA000 + 16'(i));
        swap();
        for (int i = 0; i < 4; i++) wr16(11'(100 + i), 16'hB000 + 16'(i));
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 0, 1, 11'(100 + i % 4), 0, (i == 3));
        idle(2);
        chk("t5_qb_last", 32'(QB), 32'hB003);

        // 6: reset while pending with a read in flight
        cyc(0, 0, 0, 0, 1, 11'd100, 1, 0);
        cyc(1, 0, 0, 0, 1, 11'd101, 0, 0);
        chk("t6_pend", 32'(SwapPend), 32'h0);
        chk("t6_valid", 32'(QBValid), 32'h0);
        chk("t6_qb", 32'(QB), 32'h0);
        chk("t6_front", 32'(FrontBank), 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        chk("t6_noswap", 32'(FrontBank), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
